// File: rtl/float_to_double.sv
// float_to_double: multi-cycle exact IEEE-754 single-to-double converter with reset-as-start handshake.
module float_to_double #(
  parameter bit QUIET_NAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] float,
  output logic [63:0] double,
  output logic        done,
  output logic        nan_exception
);
  typedef enum logic [2:0] {S_LOAD, S_CLASS, S_NORM, S_PACK, S_DONE} state_t;
  state_t state, state_nx;
  logic        s;
  logic [7:0]  e8;
  logic [22:0] f;
  logic [22:0] m;
  logic [10:0] e11;
  logic        is_zero, is_sub, is_max, is_nan;
  logic [63:0] res;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_LOAD;
    else state <= state_nx;
  // Exit normalisation on the shift that brings the leading one out of m;
  // the hidden bit is dropped by that same shift.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  state_nx = S_CLASS;
      S_CLASS: state_nx = is_sub ? S_NORM : S_PACK;
      S_NORM:  state_nx = m[22] ? S_PACK : S_NORM;
      S_PACK:  state_nx = S_DONE;
      default: state_nx = S_DONE;
    endcase
  end
  always_comb begin
    is_zero = e8 == 8'h00 && f == 23'd0;
    is_sub  = e8 == 8'h00 && f != 23'd0;
    is_max  = &e8;
    is_nan  = is_max && f != 23'd0;
    res = is_nan  ? {s, 11'h7FF, QUIET_NAN | f[22], f[21:0], 29'd0} :
          is_max  ? {s, 11'h7FF, 52'd0} :
          is_zero ? {s, 63'd0} :
          is_sub  ? {s, e11, m, 29'd0} :
                    {s, e11, f, 29'd0};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s             <= 1'b0;
      e8            <= 8'h00;
      f             <= 23'd0;
      m             <= 23'd0;
      e11           <= 11'd0;
      double        <= 64'd0;
      done          <= 1'b0;
      nan_exception <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          s  <= float[31];
          e8 <= float[30:23];
          f  <= float[22:0];
        end
        S_CLASS: begin
          m   <= f;
          e11 <= is_sub ? 11'd897 : {3'd0, e8} + 11'd896;
        end
        S_NORM: begin
          m   <= m << 1;
          e11 <= e11 - 11'd1;
        end
        S_PACK: begin
          double        <= res;
          nan_exception <= is_nan & ~f[22];
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_float_to_double.sv
// tb_float_to_double: directed-vector bench for float_to_double, one task per scenario.
module tb_float_to_double;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] float = 32'd0;
  logic [63:0] double;
  logic        done;
  logic        nan_exception;
  int n_cmp = 0;
  int n_bad = 0;

  float_to_double #(.QUIET_NAN(1'b1)) dut (
    .clk(clk), .reset(reset), .float(float),
    .double(double), .done(done), .nan_exception(nan_exception)
  );

  always #5 clk = ~clk;

  // Counts rising edges after release until done, sampling 1ns past each edge; -1 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done) edges = -1;
  endtask

  task automatic run_conv(input logic [31:0] v, output int edges);
    @(negedge clk); reset = 1'b0; float = v;
    @(negedge clk); reset = 1'b1;
    wait_done(edges);
  endtask

  task automatic test_reset;
    int e;
    #12;
    n_cmp++; if (double !== 64'd0) begin n_bad++; $display("FAIL reset_double got %h want %h", double, 64'd0); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (nan_exception !== 1'b0) begin n_bad++; $display("FAIL reset_nan got %b want 0", nan_exception); end
    run_conv(32'h7F800001, e);
    @(posedge clk); #2 reset = 1'b0; #1;
    n_cmp++; if (double !== 64'd0) begin n_bad++; $display("FAIL async_clr_double got %h want %h", double, 64'd0); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL async_clr_done got %b want 0", done); end
    n_cmp++; if (nan_exception !== 1'b0) begin n_bad++; $display("FAIL async_clr_nan got %b want 0", nan_exception); end
  endtask

  task automatic test_normal;
    int e;
    run_conv(32'h3F800000, e);
    n_cmp++; if (double !== 64'h3FF0000000000000) begin n_bad++; $display("FAIL one_double got %h want %h", double, 64'h3FF0000000000000); end
    n_cmp++; if (e !== 3) begin n_bad++; $display("FAIL one_latency got %0d want 3", e); end
    n_cmp++; if (nan_exception !== 1'b0) begin n_bad++; $display("FAIL one_nan got %b want 0", nan_exception); end
    run_conv(32'h80000000, e);
    n_cmp++; if (double !== 64'h8000000000000000) begin n_bad++; $display("FAIL negzero_double got %h want %h", double, 64'h8000000000000000); end
    n_cmp++; if (e !== 3) begin n_bad++; $display("FAIL negzero_latency got %0d want 3", e); end
    run_conv(32'hC0490FDB, e);
    n_cmp++; if (double !== 64'hC00921FB60000000) begin n_bad++; $display("FAIL negpi_double got %h want %h", double, 64'hC00921FB60000000); end
  endtask

  task automatic test_special;
    int e;
    run_conv(32'hFF800000, e);
    n_cmp++; if (double !== 64'hFFF0000000000000) begin n_bad++; $display("FAIL neginf_double got %h want %h", double, 64'hFFF0000000000000); end
    n_cmp++; if (nan_exception !== 1'b0) begin n_bad++; $display("FAIL neginf_nan got %b want 0", nan_exception); end
    run_conv(32'h7F800001, e);
    n_cmp++; if (double !== 64'h7FF8000020000000) begin n_bad++; $display("FAIL snan_double got %h want %h", double, 64'h7FF8000020000000); end
    n_cmp++; if (nan_exception !== 1'b1) begin n_bad++; $display("FAIL snan_nan got %b want 1", nan_exception); end
    n_cmp++; if (e !== 3) begin n_bad++; $display("FAIL snan_latency got %0d want 3", e); end
    run_conv(32'h7FC00000, e);
    n_cmp++; if (double !== 64'h7FF8000000000000) begin n_bad++; $display("FAIL qnan_double got %h want %h", double, 64'h7FF8000000000000); end
    n_cmp++; if (nan_exception !== 1'b0) begin n_bad++; $display("FAIL qnan_nan got %b want 0", nan_exception); end
  endtask

  task automatic test_subnormal;
    int e;
    run_conv(32'h00000001, e);
    n_cmp++; if (double !== 64'h36A0000000000000) begin n_bad++; $display("FAIL minsub_double got %h want %h", double, 64'h36A0000000000000); end
    n_cmp++; if (e !== 26) begin n_bad++; $display("FAIL minsub_latency got %0d want 26", e); end
    run_conv(32'h007FFFFF, e);
    n_cmp++; if (double !== 64'h380FFFFFC0000000) begin n_bad++; $display("FAIL maxsub_double got %h want %h", double, 64'h380FFFFFC0000000); end
    n_cmp++; if (e !== 4) begin n_bad++; $display("FAIL maxsub_latency got %0d want 4", e); end
    run_conv(32'h80400000, e);
    n_cmp++; if (double !== 64'hB800000000000000) begin n_bad++; $display("FAIL halfsub_double got %h want %h", double, 64'hB800000000000000); end
    n_cmp++; if (e !== 4) begin n_bad++; $display("FAIL halfsub_latency got %0d want 4", e); end
  endtask

  task automatic test_abort_and_hold;
    int e;
    @(negedge clk); reset = 1'b0; float = 32'h00000001;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0; float = 32'h3F800000; #1;
    n_cmp++; if (double !== 64'd0) begin n_bad++; $display("FAIL abort_double got %h want %h", double, 64'd0); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
    #2 reset = 1'b1;
    wait_done(e);
    n_cmp++; if (e !== 3) begin n_bad++; $display("FAIL restart_latency got %0d want 3", e); end
    n_cmp++; if (double !== 64'h3FF0000000000000) begin n_bad++; $display("FAIL restart_double got %h want %h", double, 64'h3FF0000000000000); end
    for (int i = 0; i < 20; i++) begin
      float = (i % 2 == 0) ? 32'h7F800001 : $urandom;
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b1 || double !== 64'h3FF0000000000000 || nan_exception !== 1'b0) begin
        n_bad++; $display("FAIL hold_%0d got done=%b double=%h nan=%b want done=1 double=%h nan=0", i, done, double, nan_exception, 64'h3FF0000000000000);
      end
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_special;
    test_subnormal;
    test_abort_and_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
